// File: rtl/uart_rx_frontend_pkg.sv
// Shared definitions for the UART receive front end: state encoding and defaults.
package uart_rx_frontend_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 1300;
    localparam int unsigned CNT_W                = 16;
    localparam int unsigned DATA_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_PARITY    = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_frontend_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module uart_rx_frontend_sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver (8N1, mid-bit sampling) with valid/ack hold register and error flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frontend
    import uart_rx_frontend_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_busy,
    output logic              rx_overrun,
    output logic              rx_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic              rx_parity_err
`endif
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_s;
    rx_state_e         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, busy_n, ovr_n, ferr_n, deliver;
`ifdef UART_RX_PARITY_EN
    logic              par_bad, par_bad_n, perr_n;
`endif

    uart_rx_frontend_sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_busy      <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            shreg        <= shreg_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_busy      <= busy_n;
            rx_overrun   <= ovr_n;
            rx_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad       <= par_bad_n;
            rx_parity_err <= perr_n;
`endif
        end
    end

    // Next-state, counters, shift register and handshake outputs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = rx_data;
        valid_n = rx_valid;
        ovr_n   = rx_overrun;
        ferr_n  = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif

        if (rx_valid && rx_ack) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    idx_n          = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = ^{shreg, rx_s};
                    perr_n    = ^{shreg, rx_s};
                    state_n   = ST_STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        deliver = !par_bad;
`else
                        deliver = 1'b1;
`endif
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A held, unacknowledged byte wins over the new one.
        if (deliver) begin
            if (rx_valid && !rx_ack) begin
                ovr_n = 1'b1;
            end else begin
                data_n  = shreg;
                valid_n = 1'b1;
            end
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed scenarios plus random bytes
// checked against a frame-level timing/data model (UART_RX_PARITY_EN aware).
module tb_uart_rx_frontend;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_busy      (rx_busy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records rx_valid rising edges and error pulses.
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic       prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cnt  = rise_cnt + 1;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) perr_cnt = perr_cnt + 1;
`endif
        prev_valid = rx_valid;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle (as seen at negedge) where rx_valid is expected high for a frame
    // whose start bit was driven at cycle n: 2 sync + 1 detect + H + stop-bit index * CPB.
    function automatic int exp_rise(input int n);
        return n + 3 + H + (9 + PAR) * CPB;
    endfunction

    // Drive one frame; call at a negedge. Line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb,
                              output int start_cyc);
        start_cyc = cyc;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (PAR != 0) begin
            uart_rx = parb;
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stopb;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int         n;
        int         rc;
        logic [7:0] b;

        rst_n   = 1'b0;
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",    32'(rx_data),      32'h00);
        check("reset_valid",   32'(rx_valid),     32'h0);
        check("reset_busy",    32'(rx_busy),      32'h0);
        check("reset_overrun", 32'(rx_overrun),   32'h0);
        check("reset_ferr",    32'(rx_frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic byte with ack held high: one-cycle valid pulse, exact latency.
        rx_ack = 1'b1;
        send_frame(8'hA5, 1'b1, ^8'hA5, n);
        repeat (4) @(negedge clk);
        check("a5_count",   32'(rise_cnt), 32'd1);
        check("a5_data",    32'(rise_data), 32'hA5);
        check("a5_latency", 32'(rise_cyc), 32'(exp_rise(n)));
        check("a5_pulse",   32'(rx_valid), 32'h0);
        check("a5_ferr",    32'(ferr_cnt), 32'd0);

        // Short low glitch: rejected at the start-bit mid sample.
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        check("glitch_busy_hi", 32'(rx_busy), 32'h1);
        repeat (2 * H) @(negedge clk);
        check("glitch_busy_lo", 32'(rx_busy), 32'h0);
        check("glitch_novalid", 32'(rise_cnt), 32'd1);

        // Overrun: second byte dropped while first is unacknowledged.
        rx_ack = 1'b0;
        send_frame(8'h3C, 1'b1, ^8'h3C, n);
        send_frame(8'hC3, 1'b1, ^8'hC3, n);
        repeat (4) @(negedge clk);
        check("ovr_valid", 32'(rx_valid),   32'h1);
        check("ovr_data",  32'(rx_data),    32'h3C);
        check("ovr_flag",  32'(rx_overrun), 32'h1);
        check("ovr_rises", 32'(rise_cnt),   32'd2);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        check("ack_valid",   32'(rx_valid),   32'h0);
        check("ack_overrun", 32'(rx_overrun), 32'h0);

        // Framing error followed by a break; recovery on the next frame.
        rx_ack = 1'b1;
        send_frame(8'h55, 1'b0, ^8'h55, n);
        repeat (5 * CPB) @(negedge clk);
        check("ferr_pulse",   32'(ferr_cnt), 32'd1);
        check("ferr_novalid", 32'(rise_cnt), 32'd2);
        check("ferr_waithi",  32'(rx_busy),  32'h1);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_idle", 32'(rx_busy), 32'h0);
        rx_ack = 1'b0;
        send_frame(8'h0F, 1'b1, ^8'h0F, n);
        repeat (4) @(negedge clk);
        check("after_ferr_data",    32'(rise_data), 32'h0F);
        check("after_ferr_latency", 32'(rise_cyc),  32'(exp_rise(n)));
        check("after_ferr_held",    32'(rx_valid),  32'h1);

        // Reset during data bit 4 of 8'hFF while 8'h0F is still held.
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB + H) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_data",    32'(rx_data),    32'h00);
        check("rst_valid",   32'(rx_valid),   32'h0);
        check("rst_busy",    32'(rx_busy),    32'h0);
        check("rst_overrun", 32'(rx_overrun), 32'h0);
        rc = rise_cnt;
        repeat (5 * CPB) @(negedge clk);
        check("rst_nodeliver", 32'(rise_cnt), 32'(rc));
        rx_ack = 1'b1;
        send_frame(8'h81, 1'b1, ^8'h81, n);
        repeat (4) @(negedge clk);
        check("post_rst_data",    32'(rise_data), 32'h81);
        check("post_rst_latency", 32'(rise_cyc),  32'(exp_rise(n)));

        // Random bytes against the frame-level model.
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom_range(0, 255));
            rc = rise_cnt;
            send_frame(b, 1'b1, ^b, n);
            repeat (4) @(negedge clk);
            check($sformatf("rand%0d_count", k),   32'(rise_cnt),  32'(rc + 1));
            check($sformatf("rand%0d_data", k),    32'(rise_data), 32'(b));
            check($sformatf("rand%0d_latency", k), 32'(rise_cyc),  32'(exp_rise(n)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3 * CPB)) @(negedge clk);
        end
        check("rand_ferr", 32'(ferr_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 8'h07 has three ones, so parity bit 1 is correct.
        rc = rise_cnt;
        send_frame(8'h07, 1'b1, 1'b1, n);
        repeat (4) @(negedge clk);
        check("par_ok_data",  32'(rise_data), 32'h07);
        check("par_ok_count", 32'(rise_cnt),  32'(rc + 1));
        check("par_ok_perr",  32'(perr_cnt),  32'd0);
        send_frame(8'h07, 1'b1, 1'b0, n);
        repeat (4) @(negedge clk);
        check("par_bad_perr",  32'(perr_cnt), 32'd1);
        check("par_bad_count", 32'(rise_cnt), 32'(rc + 1));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
